alu_muldiv_iter: RTL and testbench
==================================

// Module: alu_muldiv_iter
// PURPOSE
// - Parametrised multi-cycle M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the single-cycle ALU.
// - Selected when decode sees funct7=7'b0000001 on an R-type op; the pipeline stalls on in_ready/out_valid.
// - Radix-2 iterative shift-add multiply and restoring divide; one result in flight, valid/ready on both sides.
// PARAMETERS
// - XLEN        32  operand/result width; any even value >= 8
// - FAST_SPECIAL 1  1: divide-by-zero and signed overflow finish without iterating; 0: they iterate like any other op
// PORTS
// - clk        in   1     single clock, rising edge
// - rst        in   1     reset, asynchronous, active-high
// - flush      in   1     abort the op in flight; synchronous
// - in_valid   in   1     request valid
// - in_ready   out  1     unit can accept (state IDLE)
// - funct3     in   3     op select, RV32M encoding (000 MUL .. 111 REMU)
// - op_a       in   XLEN  rs1 value (ReadData1)
// - op_b       in   XLEN  rs2 value (ReadData2)
// - out_valid  out  1     result valid; held until out_ready
// - out_ready  in   1     consumer takes result
// - result     out  XLEN  result
// - busy       out  1     state != IDLE
// BEHAVIOUR
// - Reset (async): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all internal regs 0.
// - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: on in_valid&&in_ready latch funct3/op_a/op_b; take magnitudes for signed operands; counter=XLEN-1 -> CALC.
//   CALC: one add/shift or subtract/shift step per cycle; at counter==0 -> FIX.
//   FIX: apply result sign, select low/high product or quotient/remainder, register result -> DONE.
//   DONE: out_valid=1; result and out_valid stable until out_ready; on out_valid&&out_ready -> IDLE.
// - Latency: accept in cycle 0; out_valid high from cycle XLEN+2. Throughput: one op per XLEN+3 cycles when out_ready is held high.
// - in_ready is 1 only in IDLE. It is not combinationally dependent on out_ready. No accept in the DONE->IDLE cycle.
// - Signedness: MUL low XLEN bits, sign-agnostic. MULH s*s high. MULHSU s(op_a)*u(op_b) high. MULHU u*u high.
//   DIV/REM truncate toward zero. The remainder takes the sign of the dividend.
// - Special cases (RISC-V defined, no trap):
//   op_b==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//   DIV with op_a==MIN_INT and op_b==-1 -> MIN_INT; REM for the same operands -> 0.
//   With FAST_SPECIAL=1 these go IDLE->DONE directly, so out_valid is high from cycle 1.
// - Internal datapath: product accumulator 2*XLEN bits, remainder XLEN+1 bits. No overflow flag is produced.
// - flush: in CALC/FIX/DONE, next state is IDLE and out_valid=0 next cycle; the result is discarded.
//   In IDLE, flush blocks acceptance that cycle (flush has priority over in_valid).
// - rst asserted mid-op: immediate return to reset values; no partial result is visible.
// - Inputs are ignored outside IDLE; op_a/op_b may change freely after accept.
// STRUCTURE
// - Shared header (muldiv_variables.vh, alongside variables.vh/ALUvariables.vh):
//   funct3 encodings MUL..REMU, M-extension funct7 constant, state encodings (IDLE/CALC/FIX/DONE), width of the counter ($clog2(XLEN)).
// - One sub-module, muldiv_step: combinational single iteration.
//   Inputs: mode, accumulator, operand. Outputs: next accumulator, quotient bit.
// - Top level holds the FSM, counter, sign/fix-up logic and output regs.
// TESTING
// - MUL 7*-3, MULH 0x80000000*0x80000000 -> 0xFFFFFFEB, then 0x40000000.
//   out_valid exactly at cycle 34; in_ready low cycles 1-34.
// - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
// - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIV/REM/DIVU/REMU with op_b=0 and op_a=0x1234 -> 0xFFFFFFFF, 0x1234, 0xFFFFFFFF, 0x1234.
//   DIV 0x80000000/-1 -> 0x80000000. With FAST_SPECIAL=1 each of these is out_valid at cycle 1.
// - Backpressure: hold out_ready=0 for 10 cycles -> result stable and in_ready=0 throughout.
//   Release -> one handshake, IDLE next cycle.
// - flush at CALC cycle 5, then rst pulsed mid-op -> out_valid never rises.
//   A following MUL 3*5 -> 15 with normal latency; random XLEN=16 ops agree with a reference model.

Source files
------------

// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative M-extension unit: RV32M funct3 encodings,
// the M-extension funct7 value, FSM state encoding and the step-datapath mode.
package alu_muldiv_iter_pkg;

    // funct7 that routes an R-type op to this unit instead of the ALU
    localparam logic [6:0] Funct7MulDiv = 7'b0000001;

    typedef enum logic [2:0] {
        F3Mul    = 3'b000,
        F3Mulh   = 3'b001,
        F3Mulhsu = 3'b010,
        F3Mulhu  = 3'b011,
        F3Div    = 3'b100,
        F3Divu   = 3'b101,
        F3Rem    = 3'b110,
        F3Remu   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    typedef enum logic {
        StepMul = 1'b0,
        StepDiv = 1'b1
    } step_mode_e;

    // Divide family occupies the upper half of the funct3 space
    function automatic logic is_div_op(funct3_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_iter_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   mode_i    : StepMul = shift-add multiply, StepDiv = restoring divide
//   acc_i     : 2*XLEN accumulator
//                 mul: {partial product high, remaining multiplier bits}
//                 div: {partial remainder, remaining dividend / quotient bits}
//   operand_i : multiplicand (mul) or divisor (div), both as magnitudes
//   acc_o     : accumulator after this iteration (div: LSB left 0 for the quotient bit)
//   q_bit_o   : quotient bit produced by this iteration (0 in mul mode)
module alu_muldiv_iter_step
    import alu_muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  step_mode_e          mode_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     operand_i,
    output logic [2*XLEN-1:0]   acc_o,
    output logic                q_bit_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] part_rem;
    logic [XLEN:0] diff;

    always_comb begin
        // Carry of the add is kept for one cycle only: it becomes the new MSB after the shift
        sum      = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Partial remainder shifted left with the next dividend bit brought in (XLEN+1 bits)
        part_rem = acc_i[2*XLEN-1:XLEN-1];
        diff     = part_rem - {1'b0, operand_i};
        acc_o    = acc_i;
        q_bit_o  = 1'b0;
        if (mode_i == StepMul) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else begin
            // part_rem < 2*divisor, so the top bit of diff is a clean borrow
            q_bit_o = ~diff[XLEN];
            if (q_bit_o) begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = {part_rem[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Multi-cycle RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with valid/ready on
// both sides and one op in flight. Radix-2 shift-add multiply, restoring divide.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous abort of the op in flight; blocks acceptance in IDLE
//   in_valid_i   request valid          in_ready_o  accepting (IDLE only)
//   funct3_i     RV32M op select        op_a_i/op_b_i  rs1/rs2 values
//   out_valid_o  result valid (held)    out_ready_i consumer takes result
//   result_o     registered result      busy_o      state != IDLE
module alu_muldiv_iter
    import alu_muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned     CntW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q,    state_d;
    logic [CntW-1:0]     cnt_q,      cnt_d;
    funct3_e             funct3_q,   funct3_d;
    logic [2*XLEN-1:0]   acc_q,      acc_d;
    logic [XLEN-1:0]     opnd_q,     opnd_d;
    logic                neg_res_q,  neg_res_d;
    logic                neg_rem_q,  neg_rem_d;
    logic                div_zero_q, div_zero_d;
    logic [XLEN-1:0]     result_q,   result_d;

    // Request decode (only meaningful in IDLE)
    funct3_e         req_op;
    logic            req_div;
    logic            sign_a, sign_b;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            req_zero, req_ovf;
    logic [XLEN-1:0] fast_res;
    logic            accept;

    always_comb begin
        req_op   = funct3_e'(funct3_i);
        req_div  = is_div_op(req_op);
        sign_a   = req_op inside {F3Mulh, F3Mulhsu, F3Div, F3Rem};
        sign_b   = req_op inside {F3Mulh, F3Div, F3Rem};
        a_neg    = sign_a & op_a_i[XLEN-1];
        b_neg    = sign_b & op_b_i[XLEN-1];
        mag_a    = a_neg ? -op_a_i : op_a_i;
        mag_b    = b_neg ? -op_b_i : op_b_i;
        req_zero = req_div && (op_b_i == '0);
        req_ovf  = (req_op inside {F3Div, F3Rem}) && (op_a_i == MinInt) && (op_b_i == '1);
        // funct3[1] separates REM/REMU from DIV/DIVU
        fast_res = '0;
        if (req_zero) begin
            fast_res = funct3_i[1] ? op_a_i : '1;
        end else if (req_ovf) begin
            fast_res = funct3_i[1] ? '0 : MinInt;
        end
        accept   = in_valid_i && (state_q == StIdle) && !flush_i;
    end

    // One iteration of the datapath
    step_mode_e        step_mode;
    logic [2*XLEN-1:0] step_acc;
    logic              step_q_bit;

    assign step_mode = is_div_op(funct3_q) ? StepDiv : StepMul;

    alu_muldiv_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_i    (step_mode),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc),
        .q_bit_o   (step_q_bit)
    );

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        // Divide by zero leaves quotient magnitude all ones; the sign fix would corrupt it
        if (div_zero_q) begin
            quo_fix = '1;
        end
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res  = '0;
        unique case (funct3_q)
            F3Mul:                      fix_res = prod_fix[XLEN-1:0];
            F3Mulh, F3Mulhsu, F3Mulhu:  fix_res = prod_fix[2*XLEN-1:XLEN];
            F3Div, F3Divu:              fix_res = quo_fix;
            F3Rem, F3Remu:              fix_res = rem_fix;
            default:                    fix_res = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct3_d   = funct3_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d   = req_op;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = req_zero;
                    cnt_d      = CntW'(XLEN - 1);
                    if (req_div) begin
                        acc_d  = {{XLEN{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{XLEN{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    if (FAST_SPECIAL && (req_zero || req_ovf)) begin
                        result_d = fast_res;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    // Quotient bit drops into the LSB vacated by the divide shift
                    acc_d    = {step_acc[2*XLEN-1:1], step_acc[0] | step_q_bit};
                    cnt_d    = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_res;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (flush_i || out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            funct3_q   <= F3Mul;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct3_q   <= funct3_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign result_o    = result_q;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed bench for alu_muldiv_iter: a 32-bit unit with FAST_SPECIAL=1 and a 16-bit unit
// with FAST_SPECIAL=0 checked against an arithmetic reference model.
module tb_alu_muldiv_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit DUT
    logic        iv = 1'b0, ir, ov, ordy = 1'b1, busy, flush = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] a = '0, b = '0, res;

    alu_muldiv_iter #(
        .XLEN         (32),
        .FAST_SPECIAL (1'b1)
    ) u_dut32 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (iv),
        .in_ready_o  (ir),
        .funct3_i    (f3),
        .op_a_i      (a),
        .op_b_i      (b),
        .out_valid_o (ov),
        .out_ready_i (ordy),
        .result_o    (res),
        .busy_o      (busy)
    );

    // 16-bit DUT, specials iterate
    logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1, busy16, flush16 = 1'b0;
    logic [2:0]  f3_16 = 3'd0;
    logic [15:0] a16 = '0, b16 = '0, res16;

    alu_muldiv_iter #(
        .XLEN         (16),
        .FAST_SPECIAL (1'b0)
    ) u_dut16 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush16),
        .in_valid_i  (iv16),
        .in_ready_o  (ir16),
        .funct3_i    (f3_16),
        .op_a_i      (a16),
        .op_b_i      (b16),
        .out_valid_o (ov16),
        .out_ready_i (ordy16),
        .result_o    (res16),
        .busy_o      (busy16)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref16(input logic [2:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
        longint sx, sy, ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        p  = 0;
        case (op)
            3'd0: p = sx * sy;
            3'd1: p = (sx * sy) >>> 16;
            3'd2: p = (sx * uy) >>> 16;
            3'd3: p = (ux * uy) >>> 16;
            3'd4: begin
                if (y == 16'h0) p = 64'hffff;
                else if (x == 16'h8000 && y == 16'hffff) p = 64'h8000;
                else p = sx / sy;
            end
            3'd5: p = (y == 16'h0) ? 64'hffff : ux / uy;
            3'd6: begin
                if (y == 16'h0) p = ux;
                else if (x == 16'h8000 && y == 16'hffff) p = 0;
                else p = sx % sy;
            end
            default: p = (y == 16'h0) ? ux : ux % uy;
        endcase
        return p[15:0];
    endfunction

    // Issue one op, wait for the result, check latency/result/in_ready, then let it retire.
    task automatic run_op(input bit w16, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                          input string tag);
        int cyc;
        bit rdy_bad;
        if (w16) begin
            iv16 = 1'b1; f3_16 = op; a16 = x[15:0]; b16 = y[15:0];
        end else begin
            iv = 1'b1; f3 = op; a = x; b = y;
        end
        @(posedge clk); #1;
        iv = 1'b0; iv16 = 1'b0;
        a = $urandom; b = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        cyc = 1;
        rdy_bad = 1'b0;
        while (!(w16 ? ov16 : ov) && cyc < 100) begin
            if (w16 ? ir16 : ir) rdy_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (w16 ? ir16 : ir) rdy_bad = 1'b1;
        check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_res"}, w16 ? {48'd0, res16} : {32'd0, res}, {32'd0, exp});
        check_eq({tag, "_inrdy_low"}, {63'd0, rdy_bad}, 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, {63'd0, w16 ? busy16 : busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        int          bad;
        logic [15:0] rx, ry;
        logic [2:0]  rop;

        // Asynchronous reset values, before any clock edge
        #2;
        check_eq("rst_out_valid", {63'd0, ov}, 64'd0);
        check_eq("rst_in_ready", {63'd0, ir}, 64'd1);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_result", {32'd0, res}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 32-bit directed vectors
        run_op(1'b0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7x-3");
        run_op(1'b0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min");
        run_op(1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_ff");
        run_op(1'b0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_ff");
        run_op(1'b0, 3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 34, "mulh_-3x5");
        run_op(1'b0, 3'd0, 32'h12345678, 32'h10, 32'h23456780, 34, "mul_shift");
        run_op(1'b0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_-7/2");
        run_op(1'b0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem_-7/2");
        run_op(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 34, "divu_100/7");
        run_op(1'b0, 3'd7, 32'd100, 32'd7, 32'd2, 34, "remu_100/7");
        run_op(1'b0, 3'd4, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, "div_by0");
        run_op(1'b0, 3'd6, 32'h1234, 32'd0, 32'h1234, 1, "rem_by0");
        run_op(1'b0, 3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");
        run_op(1'b0, 3'd7, 32'h1234, 32'd0, 32'h1234, 1, "remu_by0");
        run_op(1'b0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        run_op(1'b0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");

        // Backpressure: result and in_ready held while out_ready is low
        ordy = 1'b0;
        iv = 1'b1; f3 = 3'd3; a = 32'h10000; b = 32'h10000;
        @(posedge clk); #1;
        iv = 1'b0;
        for (int i = 0; i < 100 && !ov; i++) begin
            @(posedge clk); #1;
        end
        check_eq("bp_valid", {63'd0, ov}, 64'd1);
        check_eq("bp_result", {32'd0, res}, 64'd1);
        held = res;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!ov || ir || res !== held) bad++;
        end
        check_eq("bp_stable", 64'(bad), 64'd0);
        ordy = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_release_valid", {63'd0, ov}, 64'd0);
        check_eq("bp_release_idle", {63'd0, ir}, 64'd1);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; iv = 1'b1; f3 = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; iv = 1'b0;
        check_eq("flush_idle_block", {63'd0, busy}, 64'd0);

        // Flush in CALC cycle 5
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_eq("flush_calc_idle", {62'd0, busy, ov}, 64'd0);

        // Reset mid-op
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_mid_result", {32'd0, res}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov || !ir) bad++;
        end
        check_eq("no_valid_after_abort", 64'(bad), 64'd0);
        run_op(1'b0, 3'd0, 32'd3, 32'd5, 32'd15, 34, "mul_3x5");

        // 16-bit unit, specials iterate (latency XLEN+2 for everything)
        run_op(1'b1, 3'd0, 32'h1234, 32'h5, 32'(ref16(3'd0, 16'h1234, 16'h5)), 18, "w16_mul");
        run_op(1'b1, 3'd1, 32'h8000, 32'h8000, 32'h4000, 18, "w16_mulh");
        run_op(1'b1, 3'd2, 32'hFFFF, 32'hFFFF, 32'hFFFF, 18, "w16_mulhsu");
        run_op(1'b1, 3'd3, 32'hFFFF, 32'hFFFF, 32'hFFFE, 18, "w16_mulhu");
        run_op(1'b1, 3'd4, 32'hFFF9, 32'h2, 32'hFFFD, 18, "w16_div");
        run_op(1'b1, 3'd6, 32'hFFF9, 32'h2, 32'hFFFF, 18, "w16_rem");
        run_op(1'b1, 3'd4, 32'h9234, 32'h0, 32'hFFFF, 18, "w16_div_by0");
        run_op(1'b1, 3'd6, 32'h9234, 32'h0, 32'h9234, 18, "w16_rem_by0");
        run_op(1'b1, 3'd4, 32'h8000, 32'hFFFF, 32'h8000, 18, "w16_div_ovf");
        run_op(1'b1, 3'd6, 32'h8000, 32'hFFFF, 32'h0, 18, "w16_rem_ovf");
        for (int i = 0; i < 8; i++) begin
            rop = 3'(i);
            rx  = 16'($urandom);
            ry  = (i == 5) ? 16'h0 : 16'($urandom);
            run_op(1'b1, rop, {16'd0, rx}, {16'd0, ry}, {16'd0, ref16(rop, rx, ry)}, 18,
                   $sformatf("w16_rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
